// File: rtl/sram_arbiter.sv
// ============================================================================
// sram_arbiter: two-port round-robin arbiter and fixed-timing SRAM sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_arbiter #(
  parameter int ADDR_BITS   = 20,
  parameter int DATA_BITS   = 48,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_cs,
  input  logic                 m0_we,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [DATA_BITS-1:0] m0_din,
  output logic [DATA_BITS-1:0] m0_dout,
  output logic                 m0_ack,
  input  logic                 m1_cs,
  input  logic                 m1_we,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [DATA_BITS-1:0] m1_din,
  output logic [DATA_BITS-1:0] m1_dout,
  output logic                 m1_ack,
  output logic                 busy,
  output logic                 grant,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_dout,
  input  logic [DATA_BITS-1:0] sram_din
);

  localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 we_lat_q, we_lat_d;
  logic                 grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] sdout_q, sdout_d;
  logic [DATA_BITS-1:0] m0_dout_q, m0_dout_d;
  logic [DATA_BITS-1:0] m1_dout_q, m1_dout_d;
  logic                 m0_ack_q, m0_ack_d;
  logic                 m1_ack_q, m1_ack_d;

  // On a tie the port that did not win last time is chosen.
  logic                 w_pick;
  assign w_pick = (m0_cs && m1_cs) ? ~grant_q : m1_cs;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_lat_d  = we_lat_q;
    grant_d   = grant_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    addr_d    = addr_q;
    sdout_d   = sdout_q;
    m0_dout_d = m0_dout_q;
    m1_dout_d = m1_dout_q;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_cs || m1_cs) begin
          grant_d  = w_pick;
          we_lat_d = w_pick ? m1_we : m0_we;
          addr_d   = w_pick ? m1_addr : m0_addr;
          ce_n_d   = 1'b0;
          we_n_d   = 1'b1;
          oe_n_d   = we_lat_d;
          if (we_lat_d) sdout_d = w_pick ? m1_din : m0_din;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d = CNT_LOAD;
        if (we_lat_q) we_n_d = 1'b0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == 8'd0) begin
          ce_n_d = 1'b1;
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          if (grant_q) m1_ack_d = 1'b1;
          else         m0_ack_d = 1'b1;
          if (!we_lat_q) begin
            if (grant_q) m1_dout_d = sram_din;
            else         m0_dout_d = sram_din;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      we_lat_q  <= 1'b0;
      grant_q   <= 1'b1;
      busy_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      addr_q    <= '0;
      sdout_q   <= '0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_lat_q  <= we_lat_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      addr_q    <= addr_d;
      sdout_q   <= sdout_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
    end
  end

  assign m0_dout   = m0_dout_q;
  assign m1_dout   = m1_dout_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_addr = addr_q;
  assign sram_dout = sdout_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// tb_sram_arbiter: directed self-checking bench for sram_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_cs, m0_we, m1_cs, m1_we;
  logic [19:0] m0_addr, m1_addr;
  logic [47:0] m0_din, m1_din;
  logic [47:0] m0_dout, m1_dout;
  logic        m0_ack, m1_ack, busy, grant;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;
  logic [47:0] sram_dout, sram_din;

  logic        s_cs, s_we;
  logic [19:0] s_addr;
  logic [47:0] s_din;
  logic [47:0] w1_dout, w1_dout1, w255_dout, w255_dout1;
  logic        w1_ack, w1_ack1, w255_ack, w255_ack1;
  logic        w1_busy, w1_grant, w1_ce_n, w1_oe_n, w1_we_n;
  logic        w255_busy, w255_grant, w255_ce_n, w255_oe_n, w255_we_n;
  logic [19:0] w1_addr, w255_addr;
  logic [47:0] w1_sdout, w255_sdout;
  logic [47:0] c_rd_val;

  int total = 0;
  int bad   = 0;
  int acks;
  int k1, k255;

  logic [47:0] mem [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_dout;
  assign sram_din = mem[sram_addr[7:0]];
  assign c_rd_val = 48'h0000CAFEF00D;

  sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(48), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cs(m0_cs), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_dout(m0_dout), .m0_ack(m0_ack),
    .m1_cs(m1_cs), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_dout(m1_dout), .m1_ack(m1_ack),
    .busy(busy), .grant(grant),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din)
  );

  sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(48), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .m0_cs(s_cs), .m0_we(s_we), .m0_addr(s_addr), .m0_din(s_din),
    .m0_dout(w1_dout), .m0_ack(w1_ack),
    .m1_cs(1'b0), .m1_we(1'b0), .m1_addr(20'h0), .m1_din(48'h0),
    .m1_dout(w1_dout1), .m1_ack(w1_ack1),
    .busy(w1_busy), .grant(w1_grant),
    .sram_ce_n(w1_ce_n), .sram_oe_n(w1_oe_n), .sram_we_n(w1_we_n),
    .sram_addr(w1_addr), .sram_dout(w1_sdout), .sram_din(c_rd_val)
  );

  sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(48), .WAIT_CYCLES(255)) u_w255 (
    .clk(clk), .rst_n(rst_n),
    .m0_cs(s_cs), .m0_we(s_we), .m0_addr(s_addr), .m0_din(s_din),
    .m0_dout(w255_dout), .m0_ack(w255_ack),
    .m1_cs(1'b0), .m1_we(1'b0), .m1_addr(20'h0), .m1_din(48'h0),
    .m1_dout(w255_dout1), .m1_ack(w255_ack1),
    .busy(w255_busy), .grant(w255_grant),
    .sram_ce_n(w255_ce_n), .sram_oe_n(w255_oe_n), .sram_we_n(w255_we_n),
    .sram_addr(w255_addr), .sram_dout(w255_sdout), .sram_din(c_rd_val)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Invariants on the main instance, checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(!sram_we_n && !sram_oe_n)) else begin
        bad++;
        $error("FAIL we_oe_overlap observed we_n=%b oe_n=%b expected not both 0", sram_we_n, sram_oe_n);
      end
      total++;
      assert (!(m0_ack && m1_ack)) else begin
        bad++;
        $error("FAIL dual_ack observed m0_ack=%b m1_ack=%b expected not both 1", m0_ack, m1_ack);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    m0_cs = 0; m0_we = 0; m0_addr = '0; m0_din = '0;
    m1_cs = 0; m1_we = 0; m1_addr = '0; m1_din = '0;
    s_cs = 0; s_we = 0; s_addr = '0; s_din = '0;
    repeat (2) @(negedge clk);

    chk("rst_ce_n", 64'(sram_ce_n), 64'd1);
    chk("rst_oe_n", 64'(sram_oe_n), 64'd1);
    chk("rst_we_n", 64'(sram_we_n), 64'd1);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_sdout", 64'(sram_dout), 64'd0);
    chk("rst_acks", {62'd0, m0_ack, m1_ack}, 64'd0);
    chk("rst_douts", 64'(m0_dout | m1_dout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 write
    m0_cs = 1; m0_we = 1; m0_addr = 20'h00010; m0_din = 48'h123456789ABC;
    @(negedge clk);
    chk("wr_setup_ce_n", 64'(sram_ce_n), 64'd0);
    chk("wr_setup_we_n", 64'(sram_we_n), 64'd1);
    chk("wr_setup_addr", 64'(sram_addr), 64'h10);
    chk("wr_setup_sdout", 64'(sram_dout), 64'h123456789ABC);
    chk("wr_setup_grant", 64'(grant), 64'd0);
    chk("wr_setup_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("wr_acc1_we_n", 64'(sram_we_n), 64'd0);
    chk("wr_acc1_ack", 64'(m0_ack), 64'd0);
    @(negedge clk);
    chk("wr_acc2_we_n", 64'(sram_we_n), 64'd0);
    @(negedge clk);
    chk("wr_done_we_n", 64'(sram_we_n), 64'd1);
    chk("wr_done_ce_n", 64'(sram_ce_n), 64'd1);
    chk("wr_done_m0_ack", 64'(m0_ack), 64'd1);
    chk("wr_done_m1_ack", 64'(m1_ack), 64'd0);
    chk("wr_done_sdout", 64'(sram_dout), 64'h123456789ABC);
    chk("wr_done_addr", 64'(sram_addr), 64'h10);
    m0_cs = 0; m0_we = 0;
    @(negedge clk);
    chk("wr_idle_ack", 64'(m0_ack), 64'd0);
    chk("wr_idle_busy", 64'(busy), 64'd0);

    // Port 1 read of the same word
    m1_cs = 1; m1_we = 0; m1_addr = 20'h00010;
    @(negedge clk);
    chk("rd_setup_oe_n", 64'(sram_oe_n), 64'd0);
    chk("rd_setup_we_n", 64'(sram_we_n), 64'd1);
    chk("rd_setup_grant", 64'(grant), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("rd_acc_oe_n", 64'(sram_oe_n), 64'd0);
    end
    @(negedge clk);
    chk("rd_done_oe_n", 64'(sram_oe_n), 64'd1);
    chk("rd_done_m1_ack", 64'(m1_ack), 64'd1);
    chk("rd_done_m0_ack", 64'(m0_ack), 64'd0);
    chk("rd_done_m1_dout", 64'(m1_dout), 64'h123456789ABC);
    chk("rd_done_m0_dout", 64'(m0_dout), 64'd0);
    m1_cs = 0;
    @(negedge clk);
    chk("rd_idle_ack", 64'(m1_ack), 64'd0);

    // Both ports held for four transactions after a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m0_cs = 1; m0_we = 1; m0_addr = 20'h00020; m0_din = 48'hA5A5A5A5A5A5;
    m1_cs = 1; m1_we = 0; m1_addr = 20'h00010;
    acks = 0;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        acks += int'(m0_ack) + int'(m1_ack);
        if (c == 0) chk("rr_grant", 64'(grant), 64'(t % 2));
        if (c == 3) begin
          if (t % 2 == 0) chk("rr_m0_ack", 64'(m0_ack), 64'd1);
          else begin
            chk("rr_m1_ack", 64'(m1_ack), 64'd1);
            chk("rr_m1_dout", 64'(m1_dout), 64'h123456789ABC);
          end
          if (t == 3) begin m0_cs = 0; m1_cs = 0; end
        end
        if (c == 4) chk("rr_idle_busy", 64'(busy), 64'd0);
      end
    end
    chk("rr_ack_count", 64'(acks), 64'd4);
    @(negedge clk);
    chk("rr_after_busy", 64'(busy), 64'd0);

    // Reset in the middle of a write
    m0_cs = 1; m0_we = 1; m0_addr = 20'h00030; m0_din = 48'h0F0F0F0F0F0F;
    @(negedge clk);
    @(negedge clk);
    chk("mid_acc_we_n", 64'(sram_we_n), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ce_n", 64'(sram_ce_n), 64'd1);
    chk("mid_rst_we_n", 64'(sram_we_n), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    m0_cs = 0; m0_we = 0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(m0_ack) + int'(m1_ack);
    end
    chk("mid_rst_no_ack", 64'(acks), 64'd0);
    rst_n = 1'b1;
    m1_cs = 1; m1_we = 0; m1_addr = 20'h00010;
    repeat (4) @(negedge clk);
    chk("post_rst_m1_ack", 64'(m1_ack), 64'd1);
    chk("post_rst_m1_dout", 64'(m1_dout), 64'h123456789ABC);
    m1_cs = 0;
    @(negedge clk);

    // Port 0 drops cs right after being granted
    m0_cs = 1; m0_we = 0; m0_addr = 20'h00010;
    @(negedge clk);
    chk("drop_grant", 64'(grant), 64'd0);
    m0_cs = 0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m0_ack) begin
        acks++;
        chk("drop_m0_dout", 64'(m0_dout), 64'h123456789ABC);
      end
    end
    chk("drop_ack_once", 64'(acks), 64'd1);
    chk("drop_idle_busy", 64'(busy), 64'd0);
    chk("drop_idle_ce_n", 64'(sram_ce_n), 64'd1);

    // Latency at the extremes of WAIT_CYCLES
    s_cs = 1; s_we = 0; s_addr = 20'h00005;
    k1 = 0; k255 = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (w1_ack && k1 == 0) k1 = k;
      if (w255_ack && k255 == 0) k255 = k;
    end
    s_cs = 0;
    chk("w1_latency", 64'(k1), 64'd3);
    chk("w255_latency", 64'(k255), 64'd257);
    chk("w1_dout", 64'(w1_dout), 64'h0000CAFEF00D);
    chk("w255_dout", 64'(w255_dout), 64'h0000CAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and access sequencer for the shared on-board SRAM (20-bit address, 48-bit data).
- Grants one requester at a time round-robin, runs a fixed-timing read or write cycle on the SRAM pins, then returns data and a one-cycle ack.
- Sits between the memory-side clients (e.g. the CPU bus bridge on port 0, the VGA frame fetcher on port 1) and the top-level tri-state split of sram_data into sram_din/sram_dout.

Parameters:
- ADDR_BITS, 20, SRAM word-address width.
- DATA_BITS, 48, SRAM data width.
- WAIT_CYCLES, 2, cycles the ACCESS state holds strobes. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  memory clock (clk_mem domain); all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_cs  in  1  port 0 request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_BITS  port 0 word address.
- m0_din  in  DATA_BITS  port 0 write data.
- m0_dout  out  DATA_BITS  port 0 read data, valid while m0_ack=1.
- m0_ack  out  1  port 0 completion pulse.
- m1_cs, m1_we, m1_addr, m1_din, m1_dout, m1_ack: identical set for port 1.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the port owning the current or most recent transaction.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- sram_addr  out  ADDR_BITS  SRAM address.
- sram_dout  out  DATA_BITS  write data to the pad driver.
- sram_din  in  DATA_BITS  read data from the pads.

Behaviour:
- Reset (async, immediate): state=IDLE; sram_ce_n=sram_oe_n=sram_we_n=1; sram_addr=0; sram_dout=0; m0_ack=m1_ack=0; m0_dout=m1_dout=0; busy=0; grant=1 (last_grant=1, so port 0 wins the first tie); wait counter=0.
- All outputs are registered.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - No cs: stay in IDLE.
  - Exactly one cs: grant that port.
  - Both cs: grant the port not equal to last_grant, then update last_grant.
  - On grant, latch we, addr and din into internal registers; go to SETUP.
  - Requesters must hold cs/we/addr/din stable until ack. The arbiter reads only the latched copies after IDLE.
- SETUP (1 cycle): sram_ce_n=0; sram_addr=latched address.
  - Read: sram_oe_n=0.
  - Write: sram_dout=latched data; sram_we_n stays 1 (address setup).
  - Load counter with WAIT_CYCLES-1; go to ACCESS.
- ACCESS (WAIT_CYCLES cycles): ce_n=0.
  - Read: oe_n=0. Write: we_n=0.
  - Counter decrements; at counter=0 go to DONE.
  - Read: sample sram_din into the granted port's dout on the last ACCESS edge.
- DONE (1 cycle):
  - we_n=1, oe_n=1, ce_n=1.
  - sram_addr and sram_dout are held (data/address hold past we_n rise).
  - Granted port's ack=1; the other port's ack=0.
  - Next state IDLE.
- Latency: cs sampled high at edge n in IDLE -> ack high during cycle n+2+WAIT_CYCLES. Total occupancy is WAIT_CYCLES+3 cycles per transaction including IDLE.
- Requester contract: drop cs or present a new request on the edge where ack is seen. cs still high in the following IDLE starts a new transaction, and round-robin still applies.
- m*_dout holds its last read value until that port's next read completes. Writes do not disturb it.
- cs dropped mid-transaction: ignored. The transaction completes and ack still pulses.
- cs asserted by the non-granted port during a transaction: waits, and is arbitrated at the next IDLE.
- Reset asserted mid-transaction: strobes go inactive immediately, no ack is issued, and the transaction is lost.
- Never both acks in one cycle. Never sram_we_n=0 together with sram_oe_n=0.

Test Plan:
- Reset with WAIT_CYCLES=2, then m0 write addr=20'h00010, din=48'h123456789ABC: SETUP 1 cycle ce_n=0/we_n=1, we_n=0 for exactly 2 cycles, DONE with m0_ack=1 in the 5th cycle after cs sampled, sram_dout held through DONE.
- m1 read of addr 20'h00010 (SRAM model returns 48'h123456789ABC): oe_n=0 for 3 cycles, m1_dout=48'h123456789ABC with m1_ack=1, m0_ack stays 0.
- m0_cs and m1_cs rise in the same cycle after reset: port 0 is served first (grant=0), then port 1 (grant=1). With both held continuously for 4 transactions, grants alternate 0,1,0,1 and exactly one ack per 5-cycle transaction.
- rst_n pulled low during the ACCESS of a write: ce_n/we_n go 1 asynchronously, no ack, FSM in IDLE. After release, a new m1 read completes normally.
- WAIT_CYCLES=1 and WAIT_CYCLES=255 builds: ack at cycle n+3 and n+257 respectively. Assertion checks: we_n and oe_n never both low, and m0_ack and m1_ack never high together.
- m0 drops cs one cycle after grant: transaction finishes and m0_ack pulses once. The next IDLE with no cs stays idle and busy=0.
